// File: rtl/sdram_model_pkg.sv
// Shared types for the SDR SDRAM chip model: command encodings, error codes,
// bank states and address field widths.
package sdram_model_pkg;

  localparam int COL_W    = 10;
  localparam int ROW_W    = 13;
  localparam int RD_DEPTH = 3;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } sdram_cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_NOT_OPEN = 3'd1,
    ERR_TRCD     = 3'd2,
    ERR_ACT      = 3'd3,
    ERR_NOT_IDLE = 3'd4,
    ERR_MODE     = 3'd5,
    ERR_COLLIDE  = 3'd6
  } sdram_err_t;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_OPEN,
    BANK_PRECHARGING
  } bank_state_t;

endpackage

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: tracks IDLE/ACTIVATING/OPEN/PRECHARGING, the open row and
// the tRCD/tRP timer. Commands arriving here have already been checked legal.
module sdram_bank_fsm
  import sdram_model_pkg::*;
#(
  parameter int T_RCD = 2,
  parameter int T_RP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic [ROW_W-1:0] row_i,
  output bank_state_t      state_o,
  output logic [ROW_W-1:0] row_o,
  output logic             can_rw,
  output logic             can_act
);

  localparam int TW = 8;

  bank_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BANK_IDLE;
      timer_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
    end
  end

  // Timer holds the remaining wait; the transition fires on the edge where
  // it reads 1 (or 0 for a one-cycle timing), so the next edge may issue.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
    case (state_q)
      BANK_IDLE: begin
        if (act_i) begin
          state_d = BANK_ACTIVATING;
          row_d   = row_i;
          timer_d = TW'(T_RCD - 1);
        end
      end
      BANK_ACTIVATING: begin
        if (timer_q <= TW'(1)) state_d = BANK_OPEN;
      end
      BANK_OPEN: begin
        if (pre_i) begin
          state_d = BANK_PRECHARGING;
          timer_d = TW'(T_RP - 1);
        end
      end
      BANK_PRECHARGING: begin
        if (timer_q <= TW'(1)) state_d = BANK_IDLE;
      end
      default: state_d = BANK_IDLE;
    endcase
  end

  always_comb begin
    state_o = state_q;
    row_o   = row_q;
    can_rw  = (state_q == BANK_OPEN);
    can_act = (state_q == BANK_IDLE);
  end

endmodule

// File: rtl/sdram_chip_model.sv
// Board-side SDR SDRAM responder: command decode, four bank FSMs, mode
// register, reduced-depth storage, CAS-latency read pipeline and error latch.
module sdram_chip_model
  import sdram_model_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  inout  wire  [15:0] sdram_dq,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt
);

  sdram_cmd_t       cmd;
  sdram_err_t       cmd_err;
  logic             cmd_ok;
  logic             mode_ok;
  logic             rd_fire, wr_fire;

  bank_state_t      bank_state [4];
  logic [ROW_W-1:0] bank_row   [4];
  logic [3:0]       bank_can_rw, bank_can_act, bank_activating;
  logic [3:0]       bank_act, bank_pre;
  logic             all_idle;

  logic [1:0]       cl_q, cl_d;
  sdram_err_t       err_code_q, err_code_d;
  logic [15:0]      refresh_q, refresh_d;

  logic [RD_DEPTH-1:0] rd_vld_q, rd_vld_d;
  logic [15:0]         rd_data_q [RD_DEPTH];
  logic [15:0]         rd_data_d [RD_DEPTH];
  logic [1:0]          ins_stage;

  logic [15:0]             mem [2**MEM_AW];
  logic [COL_W+ROW_W+1:0]  full_addr;
  logic [MEM_AW-1:0]       mem_idx;
  logic [15:0]             mem_rd_word;

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n) cmd = sdram_cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n});
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      sdram_bank_fsm #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP)
      ) u_bank (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .act_i   (bank_act[gi]),
        .pre_i   (bank_pre[gi]),
        .row_i   (sdram_addr),
        .state_o (bank_state[gi]),
        .row_o   (bank_row[gi]),
        .can_rw  (bank_can_rw[gi]),
        .can_act (bank_can_act[gi])
      );
      assign bank_activating[gi] = (bank_state[gi] == BANK_ACTIVATING);
      assign bank_act[gi] = cmd_ok && (cmd == CMD_ACT) && (sdram_ba == 2'(gi));
      assign bank_pre[gi] = cmd_ok && (cmd == CMD_PRE) && (sdram_addr[10] || sdram_ba == 2'(gi));
    end
  endgenerate

  assign all_idle = &bank_can_act;
  assign mode_ok  = ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3)) &&
                    (sdram_addr[2:0] == 3'd0);

  // Exactly one error condition per command; an erroring command has no effect.
  always_comb begin
    cmd_err = ERR_NONE;
    case (cmd)
      CMD_ACT: if (!bank_can_act[sdram_ba]) cmd_err = ERR_ACT;
      CMD_READ, CMD_WRITE: begin
        if (bank_activating[sdram_ba])  cmd_err = ERR_TRCD;
        else if (!bank_can_rw[sdram_ba]) cmd_err = ERR_NOT_OPEN;
      end
      CMD_PRE: begin
        if (sdram_addr[10] ? (|bank_activating) : bank_activating[sdram_ba]) cmd_err = ERR_TRCD;
      end
      CMD_REF: if (!all_idle) cmd_err = ERR_NOT_IDLE;
      CMD_LMR: begin
        if (!all_idle)     cmd_err = ERR_NOT_IDLE;
        else if (!mode_ok) cmd_err = ERR_MODE;
      end
      default: cmd_err = ERR_NONE;
    endcase
  end

  assign cmd_ok  = (cmd_err == ERR_NONE);
  assign rd_fire = cmd_ok && (cmd == CMD_READ);
  assign wr_fire = cmd_ok && (cmd == CMD_WRITE);

  assign full_addr   = {sdram_ba, bank_row[sdram_ba], sdram_addr[COL_W-1:0]};
  assign mem_idx     = MEM_AW'(full_addr);
  assign mem_rd_word = mem[mem_idx];

  always_comb begin
    cl_d       = cl_q;
    err_code_d = err_code_q;
    refresh_d  = refresh_q;
    if (cmd_ok && cmd == CMD_LMR) cl_d = sdram_addr[5:4];
    if (err_code_q == ERR_NONE) err_code_d = cmd_err;
    if (cmd_ok && cmd == CMD_REF && refresh_q != 16'hFFFF) refresh_d = refresh_q + 16'd1;
  end

  // Stage 0 drives dq; a read enters at stage CL-1 so it reaches stage 0
  // CL-1 edges after its command. Entries in flight keep their own latency.
  assign ins_stage = cl_q - 2'd1;

  generate
    for (gi = 0; gi < RD_DEPTH; gi++) begin : g_rd
      logic        vld_shift;
      logic [15:0] data_shift;
      if (gi == RD_DEPTH - 1) begin : g_tail
        assign vld_shift  = 1'b0;
        assign data_shift = '0;
      end else begin : g_mid
        assign vld_shift  = rd_vld_q[gi+1];
        assign data_shift = rd_data_q[gi+1];
      end
      assign rd_vld_d[gi]  = (rd_fire && ins_stage == 2'(gi)) ? 1'b1 : vld_shift;
      assign rd_data_d[gi] = (rd_fire && ins_stage == 2'(gi)) ? mem_rd_word : data_shift;
    end
  endgenerate

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cl_q       <= 2'd3;
      err_code_q <= ERR_NONE;
      refresh_q  <= '0;
      rd_vld_q   <= '0;
      for (int i = 0; i < RD_DEPTH; i++) rd_data_q[i] <= '0;
    end else begin
      cl_q       <= cl_d;
      err_code_q <= err_code_d;
      refresh_q  <= refresh_d;
      rd_vld_q   <= rd_vld_d;
      for (int i = 0; i < RD_DEPTH; i++) rd_data_q[i] <= rd_data_d[i];
    end
  end

  // Storage survives reset, so it has no reset branch.
  always_ff @(posedge clk_clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 2; b++) begin
        if (!sdram_dqm[b]) mem[mem_idx][b*8 +: 8] <= sdram_dq[b*8 +: 8];
      end
    end
  end

  assign sdram_dq    = rd_vld_q[0] ? rd_data_q[0] : {16{1'bz}};
  assign err         = (err_code_q != ERR_NONE);
  assign err_code    = err_code_q;
  assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_sdram_chip_model.sv
// Scoreboard bench for sdram_chip_model: reads push expected data and due
// cycle; a monitor pops and compares, and checks dq is released otherwise.
module tb_sdram_chip_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] sdram_addr = '0;
  logic [1:0]  sdram_ba = '0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic        cke = 1'b1;
  logic [1:0]  dqm = '0;
  wire  [15:0] sdram_dq;
  logic [15:0] tb_dq = '0;
  logic        tb_dq_en = 1'b0;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] refresh_cnt;

  assign sdram_dq = tb_dq_en ? tb_dq : {16{1'bz}};

  sdram_chip_model dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .sdram_addr  (sdram_addr),
    .sdram_ba    (sdram_ba),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_cke   (cke),
    .sdram_dqm   (dqm),
    .sdram_dq    (sdram_dq),
    .err         (err),
    .err_code    (err_code),
    .refresh_cnt (refresh_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] ref_mem [int];
  logic [12:0] open_row [4];
  int          cl_model = 3;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int mem_index(input logic [1:0] ba, input logic [12:0] row, input logic [9:0] col);
    logic [24:0] f;
    f = {ba, row, col};
    return int'(f[15:0]);
  endfunction

  task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d, input logic den);
    @(negedge clk);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    sdram_ba   = ba;
    sdram_addr = a;
    dqm        = m;
    tb_dq      = d;
    tb_dq_en   = den;
  endtask

  task automatic nop();
    drive(3'b111, 2'd0, 13'd0, 2'b00, 16'd0, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic act(input logic [1:0] ba, input logic [12:0] row);
    open_row[ba] = row;
    drive(3'b011, ba, row, 2'b00, 16'd0, 1'b0);
  endtask

  task automatic lmr(input logic [12:0] a);
    drive(3'b000, 2'd0, a, 2'b00, 16'd0, 1'b0);
    cl_model = int'(a[6:4]);
  endtask

  task automatic pre_all();
    drive(3'b010, 2'd0, 13'h0400, 2'b00, 16'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] ba, input logic [9:0] col, input logic [15:0] d, input logic [1:0] m);
    int          idx;
    logic [15:0] w;
    idx = mem_index(ba, open_row[ba], col);
    w = ref_mem.exists(idx) ? ref_mem[idx] : 16'h0000;
    if (!m[0]) w[7:0]  = d[7:0];
    if (!m[1]) w[15:8] = d[15:8];
    ref_mem[idx] = w;
    $display("wr ba=%0d col=%h data=%h dqm=%b", ba, col, d, m);
    drive(3'b100, ba, {3'b000, col}, m, d, 1'b1);
  endtask

  task automatic rd(input logic [1:0] ba, input logic [9:0] col);
    sb_t e;
    drive(3'b101, ba, {3'b000, col}, 2'b00, 16'd0, 1'b0);
    e.due  = cyc + cl_model;
    e.data = ref_mem[mem_index(ba, open_row[ba], col)];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cs_n = 1'b1;
    tb_dq_en = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cl_model = 3;
  endtask

  // dq monitor: either a scheduled read word, or released (unless bench drives).
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        $display("rd cyc=%0d dq=%h exp=%h", cyc, sdram_dq, e.data);
        check_val("rd_data", sdram_dq, e.data);
      end else if (!tb_dq_en) begin
        check_val("dq_released", 16'(sdram_dq === {16{1'bz}}), 16'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_err", 16'(err), 16'd0);
    check_val("rst_err_code", 16'(err_code), 16'd0);
    check_val("rst_refresh", refresh_cnt, 16'd0);

    // basic write/read at CL=2, WRITE at the tRCD boundary
    lmr(13'h0020);
    act(2'd1, 13'h0123);
    nop();
    wr(2'd1, 10'h045, 16'hBEEF, 2'b00);
    rd(2'd1, 10'h045);
    nops(4);
    check_val("basic_err", 16'(err), 16'd0);

    // byte masks
    wr(2'd1, 10'h046, 16'hFFFF, 2'b00);
    wr(2'd1, 10'h046, 16'h1234, 2'b10);
    rd(2'd1, 10'h046);
    nops(4);

    // CL=3, four back-to-back reads, then read-before-write ordering
    pre_all();
    nop();
    lmr(13'h0030);
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 10'h045);
    rd(2'd1, 10'h046);
    rd(2'd1, 10'h045);
    rd(2'd1, 10'h046);
    nops(5);
    rd(2'd1, 10'h045);
    wr(2'd1, 10'h045, 16'h5555, 2'b00);
    nops(4);
    rd(2'd1, 10'h045);
    nops(5);
    check_val("cl3_err", 16'(err), 16'd0);

    // refresh count, then ACTIVE inside tRP
    pre_all();
    nop();
    repeat (3) drive(3'b001, 2'd0, 13'd0, 2'b00, 16'd0, 1'b0);
    nop();
    check_val("refresh_cnt", refresh_cnt, 16'd3);
    check_val("refresh_err", 16'(err), 16'd0);
    act(2'd0, 13'h0005);
    nop();
    drive(3'b010, 2'd0, 13'h0000, 2'b00, 16'd0, 1'b0);
    act(2'd0, 13'h0005);
    nop();
    check_val("trp_err", 16'(err), 16'd1);
    check_val("trp_err_code", 16'(err_code), 16'd3);

    // READ to idle bank, then a second error must not overwrite the code
    do_reset();
    drive(3'b101, 2'd2, 13'h0000, 2'b00, 16'd0, 1'b0);
    nop();
    check_val("idle_rd_err", 16'(err), 16'd1);
    check_val("idle_rd_code", 16'(err_code), 16'd1);
    act(2'd0, 13'h0001);
    act(2'd0, 13'h0001);
    nops(3);
    check_val("first_code_kept", 16'(err_code), 16'd1);

    // async reset while read data is on the bus; array must survive
    do_reset();
    lmr(13'h0020);
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 10'h045);
    nop();
    @(negedge clk);
    check_val("pre_rst_dq", sdram_dq, 16'h5555);
    rst = 1'b1;
    sb.delete();
    #1;
    check_val("rst_dq_release", 16'(sdram_dq === {16{1'bz}}), 16'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cl_model = 3;
    check_val("post_rst_err", 16'(err), 16'd0);
    check_val("post_rst_code", 16'(err_code), 16'd0);
    check_val("post_rst_refresh", refresh_cnt, 16'd0);
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 10'h046);
    rd(2'd1, 10'h045);
    nops(6);
    check_val("final_err", 16'(err), 16'd0);
    check_val("sb_empty", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_chip_model.md
# sdram_chip_model

Synthesizable-style responder for the 16-bit SDR SDRAM port driven by the `dnn_accel_system` SDRAM controller. It sits on the board side of `sdram_addr/ba/cas_n/cke/cs_n/dq/dqm/ras_n/we_n`. It decodes the controller's commands, tracks per-bank open rows, and stores write data in a reduced-depth array. Read data is returned after the programmed CAS latency, and protocol violations are flagged so system-level benches can run the accelerator against real SDRAM timing.

## Interface
- `MEM_AW`, 16: stored word-address bits; array index = low `MEM_AW` bits of `{ba, row[12:0], col[9:0]}`.
- `T_RCD`, 2: minimum cycles from ACTIVE edge to READ/WRITE edge, same bank.
- `T_RP`, 2: minimum cycles from PRECHARGE edge to ACTIVE edge, same bank.
- `clk_clk`  in  1  SDRAM clock; all sampling on the rising edge.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `sdram_addr`  in  13  row (ACTIVE), column A9:A0 (READ/WRITE), A10 = all-banks for PRECHARGE, mode (LMR).
- `sdram_ba`  in  2  bank select.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  in  1 each  command.
- `sdram_cke`  in  1  clock enable.
- `sdram_dqm`  in  2  write byte masks; dqm[1] masks dq[15:8].
- `sdram_dq`  inout  16  data; driven only while read data is valid, else `'z`.
- `err`  out  1  sticky protocol-error flag.
- `err_code`  out  3  code of the first error; 0 = none.
- `refresh_cnt`  out  16  AUTO REFRESH count, saturating at 16'hFFFF.

## Operation
- **Command decode** when `cke`=1 and `cs_n`=0, on `{ras_n,cas_n,we_n}`:
  - 111 NOP.
  - 011 ACTIVE.
  - 101 READ.
  - 100 WRITE.
  - 010 PRECHARGE.
  - 001 AUTO REFRESH.
  - 000 LOAD MODE.
  - 110 BURST TERMINATE, treated as NOP.
- `cs_n`=1 or `cke`=0: NOP. An in-flight read still completes when `cke`=0.
- **Bank states:** IDLE → (ACTIVE) → ACTIVATING, holding T_RCD−1 counted cycles → OPEN(row).
  - OPEN → (PRECHARGE) → PRECHARGING for T_RP−1 cycles → IDLE.
  - PRECHARGE with A10=1 applies to all banks.
  - PRECHARGE of an IDLE bank is legal and a no-op.
- **WRITE to an OPEN bank:** stores dq bytes whose dqm bit is 0, at `{ba, open_row, addr[9:0]}` truncated to `MEM_AW` bits. Data is sampled on the same edge as the command.
- **READ to an OPEN bank:** the array word is captured at the command edge and enters a CL-deep pipeline. Burst length is 1. dqm is ignored for reads.
- **LOAD MODE:** legal only with all banks IDLE. A6:A4 = CL and must be 2 or 3. A2:A0 = burst length and must be 000. Illegal fields raise an error and leave the mode unchanged.
- **AUTO REFRESH:** legal only with all banks IDLE; increments `refresh_cnt`.
- **Error codes** (first one latched; `err` stays set until reset; the offending command is otherwise ignored):
  - 1: READ/WRITE to a non-OPEN bank.
  - 2: READ/WRITE/PRECHARGE before T_RCD elapsed.
  - 3: ACTIVE to a non-IDLE bank, or before T_RP elapsed.
  - 4: REFRESH/LMR with any bank not IDLE.
  - 5: illegal mode field.
  - 6: READ issued while its data slot would collide on dq with a previous read's slot, which cannot happen with BL1. Code 6 is reserved and never raised.

## Timing
- Reset values:
  - `err`=0, `err_code`=0, `refresh_cnt`=0.
  - All banks IDLE with counters 0.
  - CL=3.
  - Read pipeline empty, dq released.
- READ sampled at edge n: `sdram_dq` is driven from just after edge n+CL−1 to just after edge n+CL, so the controller samples it at edge n+CL.
- Back-to-back READs on consecutive edges produce consecutive data cycles with no gap. Drive enable stays asserted throughout.
- WRITE at edge m followed by READ of the same address at edge m+1 returns the new data.
- READ at edge n followed by WRITE to the same address at n+1 returns the old data, because capture happens at the command edge.
- LMR changing CL applies to READs issued after the LMR edge. In-flight reads keep their original latency.
- Asynchronous reset mid-read releases dq immediately and drops pending data. The array contents are not cleared.
- Bank counters load at the command edge and decrement each cycle regardless of `cke`.

## Structure
- Package `sdram_model_pkg` holds:
  - `sdram_cmd_t` enum for the 3-bit command encodings.
  - `sdram_err_t` codes 0–6.
  - Bank state enum {IDLE, ACTIVATING, OPEN, PRECHARGING}.
  - Constants COL_W=10, ROW_W=13.
- Sub-module `sdram_bank_fsm`, instantiated 4×, holds the bank state, open row, timer, and legality outputs `can_rw` and `can_act`.
- Top level holds the decode, mode register, array, read pipeline, and error latch.

## Test plan
- **Basic write/read:** reset, LMR A6:A4=3'b010, ACTIVE ba=1 row=0x123, wait 2, WRITE col=0x045 dq=0xBEEF, READ col=0x045 → dq=0xBEEF sampled 2 edges after READ, `err`=0.
- **Byte masks:** WRITE 0xFFFF, then WRITE 0x1234 with dqm=2'b10 → read returns 0xFF34.
- **CL and back-to-back:** CL=3, four back-to-back READs → four consecutive data cycles starting 3 edges after the first READ, and dq is `'z` before and after the data.
- **Protocol errors:** READ to IDLE bank 2 → `err`=1, `err_code`=1, dq stays `'z`. A later ACTIVE during ACTIVATING leaves `err_code`=1.
- **Refresh and early ACTIVE:** PRECHARGE A10=1, then 3 AUTO REFRESH → `refresh_cnt`=3. ACTIVE 1 cycle after PRECHARGE with T_RP=2 → `err_code`=3.
- **Reset mid-read:** assert `reset_reset` 1 cycle after a READ → dq released asynchronously, `err`=0. Re-ACTIVE and READ the same address → previously written data is returned.
